pads_cfg_shifter: RTL

PADS_CFG_SHIFTER -- requirements
Module: pads_cfg_shifter

---
 rtl/pads_cfg_pkg.sv | 20 ++
 rtl/pads_cfg_divider.sv | 36 +++
 rtl/pads_cfg_shifter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pads_cfg_pkg.sv
// Shared constants and state encoding for the pad configuration shifter.
package pads_cfg_pkg;

  localparam int unsigned NPADS_DEFAULT = 44;
  localparam int unsigned PHASE_W       = 4;

  localparam logic [1:0] ADDR_IO_LO = 2'd0;
  localparam logic [1:0] ADDR_IO_HI = 2'd1;
  localparam logic [1:0] ADDR_EN_LO = 2'd2;
  localparam logic [1:0] ADDR_EN_HI = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LOAD     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/pads_cfg_divider.sv
// Serial-clock phase timer: down-counter that ticks once every CLK_DIV enabled cycles.
module pads_cfg_divider
  import pads_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [PHASE_W-1:0] RELOAD = PHASE_W'(CLK_DIV - 1);

  logic [PHASE_W-1:0] cnt_q, cnt_d;

  // Held at RELOAD while disabled so the first enabled phase is full length.
  always_comb begin
    tick_o = en_i && (cnt_q == '0);
    cnt_d  = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pads_cfg_shifter.sv
// Pad configuration shifter: shadow registers serialized MSB-pad first into the
// pad control chain, then latched with serial_load.
//
// state       | meaning
// ST_IDLE     | shadows writable, waiting for start
// ST_SHIFT_LO | serial_clock low, serial_data presented
// ST_SHIFT_HI | serial_clock high, chain samples the bit
// ST_LOAD     | serial_load strobe after the last bit
// ST_DONE     | one-cycle done pulse, applied config updated
module pads_cfg_shifter
  import pads_cfg_pkg::*;
#(
  parameter int unsigned NPADS   = NPADS_DEFAULT,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             cfg_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             serial_clock,
  output logic             serial_data,
  output logic             serial_load,
  output logic [NPADS-1:0] cnfg_io,
  output logic [NPADS-1:0] cnfg_en
);

  localparam int unsigned NBITS = 2 * NPADS;
  localparam int unsigned BIT_W = $clog2(NBITS + 1);

  state_e state_q, state_d;

  logic [NPADS-1:0] io_q, io_d, en_q, en_d;
  logic [NPADS-1:0] snap_io_q, snap_io_d, snap_en_q, snap_en_d;
  logic [NPADS-1:0] cnfg_io_q, cnfg_io_d, cnfg_en_q, cnfg_en_d;
  logic [NBITS-1:0] sr_q, sr_d, sr_pack;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [63:0]      io_ext, en_ext;
  logic             phase_en, tick;

  // Shadow words are edited in a 64-bit view so the upper word truncates cleanly.
  always_comb begin
    io_ext = 64'(io_q);
    en_ext = 64'(en_q);
    if (cfg_we && (state_q == ST_IDLE)) begin
      case (cfg_addr)
        ADDR_IO_LO: io_ext[31:0]  = cfg_wdata;
        ADDR_IO_HI: io_ext[63:32] = cfg_wdata;
        ADDR_EN_LO: en_ext[31:0]  = cfg_wdata;
        ADDR_EN_HI: en_ext[63:32] = cfg_wdata;
        default: ;
      endcase
    end
    io_d = io_ext[NPADS-1:0];
    en_d = en_ext[NPADS-1:0];
  end

  always_comb begin
    sr_pack = '0;
    for (int p = 0; p < NPADS; p++) begin
      sr_pack[2*p+1] = en_q[p];
      sr_pack[2*p]   = io_q[p];
    end
  end

  assign phase_en = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI) ||
                    (state_q == ST_LOAD);

  pads_cfg_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .clk    (clk),
    .reset  (reset),
    .en_i   (phase_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    snap_io_d = snap_io_q;
    snap_en_d = snap_en_q;
    cnfg_io_d = cnfg_io_q;
    cnfg_en_d = cnfg_en_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT_LO;
          sr_d      = sr_pack;
          snap_io_d = io_q;
          snap_en_d = en_q;
          bit_cnt_d = BIT_W'(NBITS);
        end
      end
      ST_SHIFT_LO: begin
        if (tick) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (bit_cnt_q == BIT_W'(1)) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_SHIFT_LO;
            sr_d    = {sr_q[NBITS-2:0], 1'b0};
          end
        end
      end
      ST_LOAD: begin
        if (tick) begin
          state_d   = ST_DONE;
          cnfg_io_d = snap_io_q;
          cnfg_en_d = snap_en_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      io_q      <= '0;
      en_q      <= '0;
      snap_io_q <= '0;
      snap_en_q <= '0;
      cnfg_io_q <= '0;
      cnfg_en_q <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      io_q      <= io_d;
      en_q      <= en_d;
      snap_io_q <= snap_io_d;
      snap_en_q <= snap_en_d;
      cnfg_io_q <= cnfg_io_d;
      cnfg_en_q <= cnfg_en_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign cfg_ready    = (state_q == ST_IDLE);
  assign busy         = phase_en;
  assign done         = (state_q == ST_DONE);
  assign serial_clock = (state_q == ST_SHIFT_HI);
  assign serial_load  = (state_q == ST_LOAD);
  assign serial_data  = sr_q[NBITS-1];
  assign cnfg_io      = cnfg_io_q;
  assign cnfg_en      = cnfg_en_q;

endmodule
